regfile_mp_spr: RTL and testbench

Parametrised multi-port CPU register file, the next generation of the 2R/2W file. It has configurable data width, depth, and read/write port counts. Four special-purpose registers (PC, SP, LR, ST) sit at configurable indices, with a PC auto-increment path and a status write path. All conflicts resolve through a defined priority order. Reads are registered, and an optional same-cycle write-to-read bypass can be compiled in.

---
 rtl/regfile_mp_spr.sv | 103 ++++++++++
 tb/tb_regfile_mp_spr.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_spr.sv
// Parametrised multi-port register file with PC/SP/LR/ST special registers and registered reads.
// Define REGFILE_BYPASS_EN to have reads return the resolved next value of a register updated that edge.
module regfile_mp_spr #(
    parameter int unsigned     DW      = 32,
    parameter int unsigned     AW      = 5,
    parameter int unsigned     NREGS   = 32,
    parameter int unsigned     NRD     = 2,
    parameter int unsigned     NWR     = 2,
    parameter int unsigned     PC_IDX  = 31,
    parameter int unsigned     SP_IDX  = 30,
    parameter int unsigned     LR_IDX  = 29,
    parameter int unsigned     ST_IDX  = 28,
    parameter logic [DW-1:0]   PC_STEP = DW'(1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    input  logic [NRD-1:0]      read,
    output logic [NRD*DW-1:0]   rd,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*DW-1:0]   wd,
    input  logic [NWR-1:0]      write,
    input  logic [DW-1:0]       stin,
    input  logic                stwr,
    input  logic                pcincr,
    output logic [DW-1:0]       pcout,
    output logic [DW-1:0]       spout,
    output logic [DW-1:0]       lrout,
    output logic [DW-1:0]       stout
);

    logic [DW-1:0] regs     [NREGS];
    logic [DW-1:0] regs_nxt [NREGS];
    logic [DW-1:0] rd_src   [NREGS];
    logic [DW-1:0] rd_data  [NRD];
    logic [DW-1:0] rd_nxt   [NRD];

    function automatic logic in_range(input logic [AW-1:0] addr);
        return 32'(addr) < NREGS;
    endfunction

    // Lowest priority is applied first so later assignments override it:
    // pcincr, then write ports in ascending order, then stwr.
    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_nxt[i] = regs[i];
            if (i == PC_IDX && pcincr) begin
                regs_nxt[i] = regs[i] + PC_STEP;
            end
            for (int unsigned j = 0; j < NWR; j++) begin
                if (write[j] && wa[j*AW +: AW] == AW'(i)) begin
                    regs_nxt[i] = wd[j*DW +: DW];
                end
            end
            if (i == ST_IDX && stwr) begin
                regs_nxt[i] = stin;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rd_src = regs_nxt;
`else
    assign rd_src = regs;
`endif

    always_comb begin
        for (int unsigned k = 0; k < NRD; k++) begin
            rd_nxt[k] = rd_data[k];
            if (read[k]) begin
                rd_nxt[k] = in_range(ra[k*AW +: AW]) ? rd_src[ra[k*AW +: AW]] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            for (int unsigned k = 0; k < NRD; k++) begin
                rd_data[k] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= regs_nxt[i];
            end
            for (int unsigned k = 0; k < NRD; k++) begin
                rd_data[k] <= rd_nxt[k];
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign rd[k*DW +: DW] = rd_data[k];
    end

    assign pcout = regs[PC_IDX];
    assign spout = regs[SP_IDX];
    assign lrout = regs[LR_IDX];
    assign stout = regs[ST_IDX];

endmodule

// File: tb/tb_regfile_mp_spr.sv
// Self-checking bench: two configurations (32 and 24 registers) share stimulus and are
// compared every cycle against an array-based reference model, plus literal spot checks.
module tb_regfile_mp_spr;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NRD*AW-1:0] ra;
    logic [NRD-1:0]    read;
    logic [NWR*AW-1:0] wa;
    logic [NWR*DW-1:0] wd;
    logic [NWR-1:0]    write;
    logic [DW-1:0]     stin;
    logic              stwr, pcincr;
    logic [NRD*DW-1:0] rd_a, rd_b;
    logic [DW-1:0]     pc_a, sp_a, lr_a, st_a, pc_b, sp_b, lr_b, st_b;

    regfile_mp_spr u_a (
        .clk(clk), .rst(rst), .ra(ra), .read(read), .rd(rd_a), .wa(wa), .wd(wd),
        .write(write), .stin(stin), .stwr(stwr), .pcincr(pcincr),
        .pcout(pc_a), .spout(sp_a), .lrout(lr_a), .stout(st_a)
    );

    regfile_mp_spr #(
        .NREGS(24), .PC_IDX(23), .SP_IDX(22), .LR_IDX(21), .ST_IDX(20)
    ) u_b (
        .clk(clk), .rst(rst), .ra(ra), .read(read), .rd(rd_b), .wa(wa), .wd(wd),
        .write(write), .stin(stin), .stwr(stwr), .pcincr(pcincr),
        .pcout(pc_b), .spout(sp_b), .lrout(lr_b), .stout(st_b)
    );

    int checks = 0;
    int errs = 0;
    bit started = 0;

    logic [31:0] m_regs [2][32];
    logic [31:0] m_rd   [2][2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: config c=0 is 32 regs (PC31 SP30 LR29 ST28), c=1 is 24 regs (PC23..ST20).
    task automatic model_step(input int c);
        logic [31:0] nx [32];
        logic [4:0]  a;
        int lim, pci, sti;
        lim = c ? 24 : 32;
        pci = c ? 23 : 31;
        sti = c ? 20 : 28;
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[c][i] = 32'h0;
            for (int k = 0; k < 2; k++) m_rd[c][k] = 32'h0;
            return;
        end
        for (int i = 0; i < 32; i++) nx[i] = m_regs[c][i];
        if (pcincr) nx[pci] = m_regs[c][pci] + 32'd1;
        for (int j = 0; j < NWR; j++) begin
            a = wa[j*AW +: AW];
            if (write[j] && int'(a) < lim) nx[a] = wd[j*DW +: DW];
        end
        if (stwr) nx[sti] = stin;
        for (int k = 0; k < NRD; k++) begin
            if (read[k]) begin
                a = ra[k*AW +: AW];
                if (int'(a) >= lim) m_rd[c][k] = 32'h0;
                else m_rd[c][k] = BYP ? nx[a] : m_regs[c][a];
            end
        end
        for (int i = 0; i < 32; i++) m_regs[c][i] = nx[i];
    endtask

    always @(posedge clk) begin
        if (!rst) started = 1;
        model_step(0);
        model_step(1);
    end

    always @(negedge clk) begin
        if (started) begin
            chk("rd_a0", rd_a[31:0], m_rd[0][0]);
            chk("rd_a1", rd_a[63:32], m_rd[0][1]);
            chk("pc_a", pc_a, m_regs[0][31]);
            chk("sp_a", sp_a, m_regs[0][30]);
            chk("lr_a", lr_a, m_regs[0][29]);
            chk("st_a", st_a, m_regs[0][28]);
            chk("rd_b0", rd_b[31:0], m_rd[1][0]);
            chk("rd_b1", rd_b[63:32], m_rd[1][1]);
            chk("pc_b", pc_b, m_regs[1][23]);
            chk("sp_b", sp_b, m_regs[1][22]);
            chk("lr_b", lr_b, m_regs[1][21]);
            chk("st_b", st_b, m_regs[1][20]);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b1; read = '0; ra = '0; write = '0; wa = '0; wd = '0;
        stin = '0; stwr = 1'b0; pcincr = 1'b0;
    endtask

    task automatic wr(input int j, input logic [4:0] a, input logic [31:0] d);
        write[j] = 1'b1;
        wa[j*AW +: AW] = a;
        wd[j*DW +: DW] = d;
    endtask

    task automatic rdp(input int k, input logic [4:0] a);
        read[k] = 1'b1;
        ra[k*AW +: AW] = a;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        tick();
        chk("reset_pc", pc_a, 32'h0);
        chk("reset_rd", rd_a[31:0], 32'h0);

        // Load, then reset mid-operation with a write pending.
        idle(); wr(0, 5'd3, 32'hA5); tick();
        idle(); wr(0, 5'd31, 32'h10); tick();
        chk("pc_load", pc_a, 32'h10);
        idle(); rst = 1'b0; wr(0, 5'd5, 32'h77); rdp(0, 5'd3); tick();
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_rd", rd_a[31:0], 32'h0);
        idle(); rdp(0, 5'd3); rdp(1, 5'd5); tick();
        chk("rst_reg3", rd_a[31:0], 32'h0);
        chk("rst_wr_ignored", rd_a[63:32], 32'h0);

        // Same-address port conflict: higher port wins.
        idle(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); tick();
        idle(); rdp(0, 5'd7); tick();
        chk("conflict", rd_a[31:0], 32'h22);

        // PC wrap and branch-over-increment.
        idle(); wr(0, 5'd31, 32'hFFFF_FFFF); tick();
        idle(); pcincr = 1'b1; tick();
        chk("pc_wrap", pc_a, 32'h0);
        idle(); pcincr = 1'b1; wr(0, 5'd31, 32'h100); tick();
        chk("pc_branch", pc_a, 32'h100);
        idle(); pcincr = 1'b1; tick();
        chk("pc_inc", pc_a, 32'h101);

        idle(); stwr = 1'b1; stin = 32'h3; wr(1, 5'd28, 32'h9); tick();
        chk("st_prio", st_a, 32'h3);

        // Read/write collision and read hold.
        idle(); wr(0, 5'd5, 32'h1); tick();
        idle(); rdp(0, 5'd5); wr(0, 5'd5, 32'hBEEF); tick();
        chk("rw_collide", rd_a[31:0], BYP ? 32'hBEEF : 32'h1);
        idle(); ra[4:0] = 5'd3; tick();
        chk("rd_hold", rd_a[31:0], BYP ? 32'hBEEF : 32'h1);
        idle(); rdp(0, 5'd31); pcincr = 1'b1; tick();
        chk("pc_rd_collide", rd_a[31:0], BYP ? 32'h102 : 32'h101);
        chk("pc_after", pc_a, 32'h102);

        // Out of range in the 24-register instance.
        idle(); wr(0, 5'd30, 32'h5A); rdp(0, 5'd30); tick();
        chk("oor_rd_b", rd_b[31:0], 32'h0);
        chk("oor_pc_b", pc_b, 32'h4);
        chk("oor_st_b", st_b, 32'h3);

        for (int n = 0; n < 3000; n++) begin
            idle();
            rst    = ($urandom_range(0, 63) != 0);
            read   = 2'($urandom);
            ra     = 10'($urandom);
            write  = 2'($urandom);
            wa     = 10'($urandom);
            wd     = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) wd[31:0] = 32'hFFFF_FFFF;
            stin   = $urandom();
            stwr   = ($urandom_range(0, 3) == 0);
            pcincr = ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
